// File: rtl/dest_reg_tracker.sv
// Destination-register tracker: carries the selected write register through the
// EX/MEM/WB slots, and derives the EX forwarding selects and the load-use stall.
module dest_reg_tracker #(
    parameter int unsigned REG_W      = 5,
    parameter bit          ZERO_GUARD = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [REG_W-1:0] WriteReg_ID,
    input  logic             RegWrite_ID,
    input  logic             MemRead_ID,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             UsesRt_ID,
    input  logic             Flush,
    input  logic             Hold,
    output logic             Stall,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [REG_W-1:0] WriteReg_MEM,
    output logic             RegWrite_MEM,
    output logic [REG_W-1:0] WriteReg_WB,
    output logic             RegWrite_WB
);

    // EX slot keeps its sources for forwarding; MemRead is only consumed by the
    // load-use check while the load sits in EX, so later slots do not carry it.
    logic [REG_W-1:0] ex_wr_q, ex_rs_q, ex_rt_q;
    logic             ex_rw_q, ex_mr_q;
    logic [REG_W-1:0] mem_wr_q, wb_wr_q;
    logic             mem_rw_q, wb_rw_q;

    logic             ex_wr_valid, mem_wr_valid, wb_wr_valid;
    logic             mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
    logic             stall;

    // Register 0 is never a real producer when the guard is enabled.
    assign ex_wr_valid  = !ZERO_GUARD || (ex_wr_q != '0);
    assign mem_wr_valid = !ZERO_GUARD || (mem_wr_q != '0);
    assign wb_wr_valid  = !ZERO_GUARD || (wb_wr_q != '0);

    assign mem_hit_rs = mem_rw_q && mem_wr_valid && (mem_wr_q == ex_rs_q);
    assign mem_hit_rt = mem_rw_q && mem_wr_valid && (mem_wr_q == ex_rt_q);
    assign wb_hit_rs  = wb_rw_q && wb_wr_valid && (wb_wr_q == ex_rs_q);
    assign wb_hit_rt  = wb_rw_q && wb_wr_valid && (wb_wr_q == ex_rt_q);

    // Load in EX whose result the ID instruction needs next cycle.
    assign stall = ex_mr_q && ex_rw_q && ex_wr_valid &&
                   ((ex_wr_q == Rs_ID) || (UsesRt_ID && (ex_wr_q == Rt_ID)));

    assign Stall        = stall;
    assign WriteReg_MEM = mem_wr_q;
    assign RegWrite_MEM = mem_rw_q;
    assign WriteReg_WB  = wb_wr_q;
    assign RegWrite_WB  = wb_rw_q;

    // Operand selects: MEM beats WB so the newest value wins.
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (mem_hit_rs) begin
            ForwardA = 2'b10;
        end else if (wb_hit_rs) begin
            ForwardA = 2'b01;
        end
        if (mem_hit_rt) begin
            ForwardB = 2'b10;
        end else if (wb_hit_rt) begin
            ForwardB = 2'b01;
        end
    end

    // Slot advance: Hold freezes everything; stall or flush inserts one bubble into EX.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_wr_q  <= '0;
            ex_rs_q  <= '0;
            ex_rt_q  <= '0;
            ex_rw_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_wr_q <= '0;
            mem_rw_q <= 1'b0;
            wb_wr_q  <= '0;
            wb_rw_q  <= 1'b0;
        end else if (!Hold) begin
            wb_wr_q  <= mem_wr_q;
            wb_rw_q  <= mem_rw_q;
            mem_wr_q <= ex_wr_q;
            mem_rw_q <= ex_rw_q;
            if (stall || Flush) begin
                ex_wr_q <= '0;
                ex_rs_q <= '0;
                ex_rt_q <= '0;
                ex_rw_q <= 1'b0;
                ex_mr_q <= 1'b0;
            end else begin
                ex_wr_q <= WriteReg_ID;
                ex_rs_q <= Rs_ID;
                ex_rt_q <= Rt_ID;
                ex_rw_q <= RegWrite_ID;
                ex_mr_q <= MemRead_ID;
            end
        end
    end

endmodule
